dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single dTLB/dCache load-store port between NUM_REQ requesters, e.g. scalar core LSU and vector unit memory interface.
- Sits upstream of the per-port load/store sequencing FSM. Drives its is_load/is_store/kill inputs and watches its lock, store-ready and load-response outputs.
- Grants are round-robin and held per request until completion, kill or timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TMO_W, 8, width of the watchdog counter; timeout fires after 2^TMO_W-1 BUSY cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_ld_i  in  NUM_REQ  per-requester load request, level, held until done
- req_st_i  in  NUM_REQ  per-requester store request, level, held until done
- req_kill_i  in  NUM_REQ  per-requester kill of an outstanding op
- gnt_o  out  NUM_REQ  one-hot grant, held ISSUE..DRAIN
- done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
- is_load_o  out  1  load request to the port FSM, one-cycle pulse
- is_store_o  out  1  store request to the port FSM, one-cycle pulse
- kill_mem_op_o  out  1  kill to the port FSM, held through DRAIN
- dmem_lock_i  in  1  port FSM busy/lock
- str_rdy_i  in  1  store accepted by the port FSM
- ld_resp_valid_i  in  1  load response valid
- timeout_o  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; rr_ptr=0; counter=0.
- A requester is eligible when (req_ld_i[i]|req_st_i[i]) & !req_kill_i[i].
- If both req_ld_i[i] and req_st_i[i] are set, it is treated as a load.
- All outputs are registered.
- IDLE:
  - Waits for !dmem_lock_i and at least one eligible requester.
  - Picks the first eligible index starting at rr_ptr, wrapping NUM_REQ-1 -> 0.
  - Latches the index and op type; sets gnt_o; goes to ISSUE.
  - rr_ptr = (winner+1) mod NUM_REQ.
- ISSUE (1 cycle):
  - Pulses is_load_o or is_store_o.
  - If req_kill_i[gnt] is asserted in this cycle, suppresses the pulse, sets kill_mem_op_o and goes to DRAIN.
  - Otherwise goes to BUSY and clears the counter.
- BUSY:
  - Counter increments every cycle.
  - Done condition: ld_resp_valid_i for loads, str_rdy_i for stores.
  - On done: done_o[gnt]=1 for exactly 1 cycle, then DRAIN.
  - Else if req_kill_i[gnt]: kill_mem_op_o=1, no done_o, then DRAIN.
  - Else if counter is all ones: timeout_o pulse, kill_mem_op_o=1, done_o[gnt] pulse (requester must retire), then DRAIN.
  - Priority is done > kill > timeout.
  - Responses arriving in IDLE or DRAIN are ignored.
- DRAIN:
  - Waits for dmem_lock_i=0, then goes to IDLE next cycle.
  - On that transition: gnt_o=0, kill_mem_op_o=0.
  - Guarantees at least one idle cycle between ops.
- Non-granted requesters' kills have no effect. Requests that drop before grant are simply not chosen.
- At most one op is outstanding; gnt_o is one-hot or zero at all times.
- Reset mid-operation returns to IDLE at once. No kill is sent; the port FSM is reset by the same rst.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, DRAIN=2'd3);
  - the OP_LD/OP_ST encoding;
  - the default TMO_W.
- One sub-module: rr_picker (combinational rotate-priority select, eligible vector + rr_ptr -> one-hot winner, index and any_valid).
- The watchdog counter stays inline.

Test Plan:
- Single load: req_ld_i=01, ld_resp_valid_i 5 cycles after is_load_o -> gnt_o=01, is_load_o one pulse, done_o=01 one cycle later, gnt_o=00 after dmem_lock_i falls.
- Contention: req_st_i=11 held continuously, each completes via str_rdy_i -> grants alternate 01,10,01; rr_ptr wraps; no back-to-back grant without a DRAIN/IDLE cycle.
- Kill in BUSY: req_kill_i[0]=1 3 cycles after a load issue -> kill_mem_op_o=1 until dmem_lock_i=0; no done_o; a later ld_resp_valid_i is ignored.
- Timeout with TMO_W=3 and no response -> timeout_o and done_o pulse after 7 BUSY cycles, kill_mem_op_o asserted.
- Lock held: dmem_lock_i=1 in IDLE with req_ld_i=10 -> no grant until dmem_lock_i=0, then gnt_o=10 next cycle.
- Async reset asserted in BUSY -> all outputs 0 immediately; after release, first grant goes to index 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the dTLB/dCache port arbiter: FSM states, op type
// and the default watchdog width.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

   typedef enum logic {
      OP_LD = 1'b0,
      OP_ST = 1'b1
   } arb_op_e;

   localparam int TMO_W_DEF = 8;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority select: first eligible requester at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] elig_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [IDX_W-1:0]   win_idx_o,
   output logic               any_o
);

   always_comb begin
      int j;
      j         = 0;
      win_oh_o  = '0;
      win_idx_o = '0;
      any_o     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_o && elig_i[IDX_W'(j)]) begin
            any_o                  = 1'b1;
            win_oh_o[IDX_W'(j)]    = 1'b1;
            win_idx_o              = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one dTLB/dCache load-store port between
// NUM_REQ requesters; one op outstanding, held until done, kill or timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | port free; grant when unlocked and someone is eligible
//   ST_ISSUE | grant held; fire is_load/is_store next unless killed
//   ST_BUSY  | waiting for response, kill or watchdog expiry
//   ST_DRAIN | op finished; wait for port FSM to drop its lock
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TMO_W   = TMO_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_ld_i,
   input  logic [NUM_REQ-1:0] req_st_i,
   input  logic [NUM_REQ-1:0] req_kill_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [NUM_REQ-1:0] done_o,
   output logic               is_load_o,
   output logic               is_store_o,
   output logic               kill_mem_op_o,
   input  logic               dmem_lock_i,
   input  logic               str_rdy_i,
   input  logic               ld_resp_valid_i,
   output logic               timeout_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e         state_q, state_d;
   arb_op_e            op_q, op_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               is_load_q, is_load_d;
   logic               is_store_q, is_store_d;
   logic               kill_q, kill_d;
   logic               timeout_q, timeout_d;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic               kill_gnt;
   logic               resp_done;

   assign elig      = (req_ld_i | req_st_i) & ~req_kill_i;
   assign kill_gnt  = req_kill_i[gnt_idx_q];
   assign resp_done = (op_q == OP_LD) ? ld_resp_valid_i : str_rdy_i;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .elig_i    (elig),
      .ptr_i     (rr_ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .any_o     (win_any)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      gnt_idx_d  = gnt_idx_q;
      rr_ptr_d   = rr_ptr_q;
      tmo_cnt_d  = tmo_cnt_q;
      gnt_d      = gnt_q;
      kill_d     = kill_q;
      done_d     = '0;
      is_load_d  = 1'b0;
      is_store_d = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!dmem_lock_i && win_any) begin
               state_d   = ST_ISSUE;
               gnt_d     = win_oh;
               gnt_idx_d = win_idx;
               op_d      = req_ld_i[win_idx] ? OP_LD : OP_ST;
               rr_ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         ST_ISSUE: begin
            if (kill_gnt) begin
               kill_d  = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               is_load_d  = (op_q == OP_LD);
               is_store_d = (op_q == OP_ST);
               tmo_cnt_d  = '1;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Down-counter from all ones: terminal count zero is reached on
            // the same BUSY cycle an up-counter from zero would hit all ones.
            tmo_cnt_d = tmo_cnt_q - 1'b1;
            if (resp_done) begin
               done_d[gnt_idx_q] = 1'b1;
               state_d           = ST_DRAIN;
            end else if (kill_gnt) begin
               kill_d  = 1'b1;
               state_d = ST_DRAIN;
            end else if (tmo_cnt_q == '0) begin
               timeout_d         = 1'b1;
               kill_d            = 1'b1;
               done_d[gnt_idx_q] = 1'b1;
               state_d           = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!dmem_lock_i) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               kill_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_LD;
         gnt_idx_q  <= '0;
         rr_ptr_q   <= '0;
         tmo_cnt_q  <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         is_load_q  <= 1'b0;
         is_store_q <= 1'b0;
         kill_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         gnt_idx_q  <= gnt_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         tmo_cnt_q  <= tmo_cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         is_load_q  <= is_load_d;
         is_store_q <= is_store_d;
         kill_q     <= kill_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt_o         = gnt_q;
   assign done_o        = done_q;
   assign is_load_o     = is_load_q;
   assign is_store_o    = is_store_q;
   assign kill_mem_op_o = kill_q;
   assign timeout_o     = timeout_q;

endmodule
